// File: rtl/fb_rect_writer.sv
// fb_rect_writer: solid-rectangle fill engine for the 320x240 8-bit framebuffer.
// Accepts one command over valid/ready, clips it to the screen and writes one
// pixel per clock in raster order through a synchronous-write RAM port.
// Optional build macro FB_WRITER_VSYNC_WAIT_EN: adds the frame_sync input and a
// WAIT_SYNC state so that filling starts only at the start of vertical blank.
module fb_rect_writer #(
  parameter int RES_X      = 320,
  parameter int RES_Y      = 240,
  parameter int MEM_WIDTH  = 8,
  parameter int ADDR_WIDTH = $clog2(RES_X * RES_Y)
) (
  input  logic                  clk,
  input  logic                  rst_n,
`ifdef FB_WRITER_VSYNC_WAIT_EN
  input  logic                  frame_sync,
`endif
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [8:0]            cmd_x,
  input  logic [7:0]            cmd_y,
  input  logic [8:0]            cmd_w,
  input  logic [7:0]            cmd_h,
  input  logic [MEM_WIDTH-1:0]  cmd_color,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [MEM_WIDTH-1:0]  din,
  output logic                  wen,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    FILL,
`ifdef FB_WRITER_VSYNC_WAIT_EN
    WAIT_SYNC,
`endif
    DONE
  } state_t;

  // 10-bit screen limits so x+w and y+h never overflow
  localparam logic [9:0] RES_X_W = 10'(RES_X);
  localparam logic [9:0] RES_Y_W = 10'(RES_Y);

  state_t                state_q;
  logic [8:0]            x_q;
  logic [7:0]            y_q;
  logic [8:0]            w_q;
  logic [7:0]            h_q;
  logic [MEM_WIDTH-1:0]  color_q;
  logic [9:0]            x_end_q;
  logic [9:0]            y_end_q;
  logic [9:0]            col_q;
  logic [9:0]            row_q;
  logic [ADDR_WIDTH-1:0] row_base_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [MEM_WIDTH-1:0]  din_q;
  logic                  wen_q;
  logic                  done_q;

  logic [9:0]            sum_x_d;
  logic [9:0]            sum_y_d;
  logic [9:0]            x_end_d;
  logic [9:0]            y_end_d;
  logic                  empty_d;
  logic [ADDR_WIDTH-1:0] row_base_d;
  logic [ADDR_WIDTH-1:0] row_next_d;
  logic                  last_col_d;
  logic                  last_row_d;

  // Clipping, empty detection and address arithmetic from the captured command
  always_comb begin
    sum_x_d    = {1'b0, x_q} + {1'b0, w_q};
    sum_y_d    = {2'b00, y_q} + {2'b00, h_q};
    x_end_d    = (sum_x_d > RES_X_W) ? RES_X_W : sum_x_d;
    y_end_d    = (sum_y_d > RES_Y_W) ? RES_Y_W : sum_y_d;
    empty_d    = (w_q == 9'd0) || (h_q == 8'd0) ||
                 ({1'b0, x_q} >= RES_X_W) || ({2'b00, y_q} >= RES_Y_W);
    // constant multiply, only used once per command in SETUP
    row_base_d = ADDR_WIDTH'(y_q) * ADDR_WIDTH'(RES_X);
    row_next_d = row_base_q + ADDR_WIDTH'(RES_X);
    last_col_d = (col_q == (x_end_q - 10'd1));
    last_row_d = (row_q == (y_end_q - 10'd1));
  end

  // Command FSM with registered RAM-port outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      x_q        <= '0;
      y_q        <= '0;
      w_q        <= '0;
      h_q        <= '0;
      color_q    <= '0;
      x_end_q    <= '0;
      y_end_q    <= '0;
      col_q      <= '0;
      row_q      <= '0;
      row_base_q <= '0;
      addr_q     <= '0;
      din_q      <= '0;
      wen_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            x_q     <= cmd_x;
            y_q     <= cmd_y;
            w_q     <= cmd_w;
            h_q     <= cmd_h;
            color_q <= cmd_color;
            state_q <= SETUP;
          end
        end
        SETUP: begin
          x_end_q    <= x_end_d;
          y_end_q    <= y_end_d;
          col_q      <= {1'b0, x_q};
          row_q      <= {2'b00, y_q};
          row_base_q <= row_base_d;
          din_q      <= color_q;
          if (empty_d) begin
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
`ifdef FB_WRITER_VSYNC_WAIT_EN
            state_q <= WAIT_SYNC;
`else
            wen_q   <= 1'b1;
            addr_q  <= row_base_d + ADDR_WIDTH'(x_q);
            state_q <= FILL;
`endif
          end
        end
`ifdef FB_WRITER_VSYNC_WAIT_EN
        WAIT_SYNC: begin
          // hold off drawing until vertical blank to avoid tearing
          if (frame_sync) begin
            wen_q   <= 1'b1;
            addr_q  <= row_base_q + ADDR_WIDTH'(col_q);
            state_q <= FILL;
          end
        end
`endif
        FILL: begin
          if (last_col_d) begin
            if (last_row_d) begin
              wen_q   <= 1'b0;
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              col_q      <= {1'b0, x_q};
              row_q      <= row_q + 10'd1;
              row_base_q <= row_next_d;
              addr_q     <= row_next_d + ADDR_WIDTH'(x_q);
            end
          end else begin
            col_q  <= col_q + 10'd1;
            addr_q <= addr_q + ADDR_WIDTH'(1);
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          wen_q   <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign mem_addr  = addr_q;
  assign din       = din_q;
  assign wen       = wen_q;
  assign done      = done_q;

endmodule

// File: tb/tb_fb_rect_writer.sv
// Directed bench for fb_rect_writer: reset, basic fill, clipping, empty
// commands, back-to-back handshake, reset during a fill, optional vsync wait.
module tb_fb_rect_writer;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [8:0]  cmd_x;
  logic [7:0]  cmd_y;
  logic [8:0]  cmd_w;
  logic [7:0]  cmd_h;
  logic [7:0]  cmd_color;
  logic [16:0] mem_addr;
  logic [7:0]  din;
  logic        wen;
  logic        busy;
  logic        done;
`ifdef FB_WRITER_VSYNC_WAIT_EN
  logic        frame_sync;
`endif

  int checks = 0;
  int errors = 0;

  int          wr_addr[$];
  logic [7:0]  wr_din[$];
  int          first_wen;
  int          done_at;
  logic        acc_ready;
  logic        overflow;

  fb_rect_writer dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef FB_WRITER_VSYNC_WAIT_EN
    .frame_sync(frame_sync),
`endif
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_x     (cmd_x),
    .cmd_y     (cmd_y),
    .cmd_w     (cmd_w),
    .cmd_h     (cmd_h),
    .cmd_color (cmd_color),
    .mem_addr  (mem_addr),
    .din       (din),
    .wen       (wen),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one command for one cycle and collect every write until done.
  // Sample index n=0 is the handshake cycle; n counts negedges after it.
  task automatic run_cmd(input logic [8:0] x, input logic [7:0] y,
                         input logic [8:0] w, input logic [7:0] h,
                         input logic [7:0] c);
    int n;
    wr_addr.delete();
    wr_din.delete();
    first_wen = -1;
    done_at   = -1;
    overflow  = 1'b0;
    @(negedge clk);
    cmd_x = x; cmd_y = y; cmd_w = w; cmd_h = h; cmd_color = c;
    cmd_valid = 1'b1;
    acc_ready = cmd_ready;
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 1;
    while (done_at < 0 && n < 3000) begin
      if (wen) begin
        wr_addr.push_back(int'(mem_addr));
        wr_din.push_back(din);
        if (first_wen < 0) first_wen = n;
        if (mem_addr >= 17'd76800) overflow = 1'b1;
      end
      if (done) done_at = n;
      else begin
        @(negedge clk);
        n++;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b1;
    cmd_valid = 1'b0;
    cmd_x = '0; cmd_y = '0; cmd_w = '0; cmd_h = '0; cmd_color = '0;
`ifdef FB_WRITER_VSYNC_WAIT_EN
    frame_sync = 1'b0;
`endif
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready got=%b exp=1", cmd_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (wen !== 1'b0) begin errors++; $display("FAIL reset_wen got=%b exp=0", wen); end
    checks++; if (mem_addr !== 17'd0) begin errors++; $display("FAIL reset_mem_addr got=%0d exp=0", mem_addr); end
    checks++; if (din !== 8'd0) begin errors++; $display("FAIL reset_din got=%0h exp=0", din); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic_fill;
    int exp_a[6];
    int got;
    exp_a = '{1610, 1611, 1612, 1930, 1931, 1932};
    run_cmd(9'd10, 8'd5, 9'd3, 8'd2, 8'h2A);
    checks++; if (acc_ready !== 1'b1) begin errors++; $display("FAIL basic_accept_ready got=%b exp=1", acc_ready); end
    checks++; if (wr_addr.size() != 6) begin errors++; $display("FAIL basic_write_count got=%0d exp=6", wr_addr.size()); end
    for (int i = 0; i < 6; i++) begin
      got = (i < wr_addr.size()) ? wr_addr[i] : -1;
      checks++; if (got != exp_a[i]) begin errors++; $display("FAIL basic_addr[%0d] got=%0d exp=%0d", i, got, exp_a[i]); end
      got = (i < wr_din.size()) ? int'(wr_din[i]) : -1;
      checks++; if (got != 'h2A) begin errors++; $display("FAIL basic_din[%0d] got=%0h exp=2a", i, got); end
    end
    checks++; if (first_wen != 2) begin errors++; $display("FAIL basic_first_wen_latency got=%0d exp=2", first_wen); end
    checks++; if (done_at != 8) begin errors++; $display("FAIL basic_done_cycle got=%0d exp=8", done_at); end
    checks++; if (done_at + 1 != 9) begin errors++; $display("FAIL basic_busy_span got=%0d exp=9", done_at + 1); end
    @(negedge clk);
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL basic_ready_after_done got=%b exp=1", cmd_ready); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_one_cycle got=%b exp=0", done); end
  endtask

  task automatic test_clipping;
    int got;
    run_cmd(9'd318, 8'd239, 9'd5, 8'd4, 8'h3F);
    checks++; if (wr_addr.size() != 2) begin errors++; $display("FAIL clip_write_count got=%0d exp=2", wr_addr.size()); end
    got = (wr_addr.size() > 0) ? wr_addr[0] : -1;
    checks++; if (got != 76798) begin errors++; $display("FAIL clip_addr0 got=%0d exp=76798", got); end
    got = (wr_addr.size() > 1) ? wr_addr[1] : -1;
    checks++; if (got != 76799) begin errors++; $display("FAIL clip_addr1 got=%0d exp=76799", got); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL clip_addr_overflow got=%b exp=0", overflow); end
    checks++; if (done_at != 4) begin errors++; $display("FAIL clip_done_cycle got=%0d exp=4", done_at); end
    @(negedge clk);
  endtask

  task automatic test_empty;
    logic [8:0] ex[4];
    logic [7:0] ey[4];
    logic [8:0] ew[4];
    logic [7:0] eh[4];
    ex = '{9'd5, 9'd5, 9'd320, 9'd5};
    ey = '{8'd5, 8'd5, 8'd5, 8'd240};
    ew = '{9'd0, 9'd4, 9'd4, 9'd4};
    eh = '{8'd4, 8'd0, 8'd4, 8'd4};
    for (int k = 0; k < 4; k++) begin
      run_cmd(ex[k], ey[k], ew[k], eh[k], 8'h11);
      checks++; if (wr_addr.size() != 0) begin errors++; $display("FAIL empty%0d_writes got=%0d exp=0", k, wr_addr.size()); end
      checks++; if (done_at != 2) begin errors++; $display("FAIL empty%0d_done_cycle got=%0d exp=2", k, done_at); end
      @(negedge clk);
      checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL empty%0d_ready got=%b exp=1", k, cmd_ready); end
    end
  endtask

  task automatic test_back_to_back;
    int acc_n[$];
    int wa[$];
    int wd[$];
    int done_cnt;
    int got;
    done_cnt = 0;
    @(negedge clk);
    cmd_x = 9'd7; cmd_y = 8'd3; cmd_w = 9'd1; cmd_h = 8'd1; cmd_color = 8'h11;
    cmd_valid = 1'b1;
    for (int n = 0; n <= 10; n++) begin
      if (n == 1) begin
        cmd_x = 9'd20; cmd_y = 8'd10; cmd_color = 8'h22;
      end
      if (n == 5) begin
        cmd_valid = 1'b0;
        cmd_x = 9'd100; cmd_y = 8'd100; cmd_color = 8'h33;
      end
      if (cmd_valid && cmd_ready) acc_n.push_back(n);
      if (wen) begin
        wa.push_back(int'(mem_addr));
        wd.push_back(int'(din));
      end
      if (done) done_cnt++;
      @(negedge clk);
    end
    checks++; if (acc_n.size() != 2) begin errors++; $display("FAIL b2b_accept_count got=%0d exp=2", acc_n.size()); end
    got = (acc_n.size() > 1) ? acc_n[1] : -1;
    checks++; if (got != 4) begin errors++; $display("FAIL b2b_second_accept_cycle got=%0d exp=4", got); end
    checks++; if (wa.size() != 2) begin errors++; $display("FAIL b2b_write_count got=%0d exp=2", wa.size()); end
    got = (wa.size() > 0) ? wa[0] : -1;
    checks++; if (got != 967) begin errors++; $display("FAIL b2b_addr0 got=%0d exp=967", got); end
    got = (wd.size() > 0) ? wd[0] : -1;
    checks++; if (got != 'h11) begin errors++; $display("FAIL b2b_din0 got=%0h exp=11", got); end
    got = (wa.size() > 1) ? wa[1] : -1;
    checks++; if (got != 3220) begin errors++; $display("FAIL b2b_addr1 got=%0d exp=3220", got); end
    got = (wd.size() > 1) ? wd[1] : -1;
    checks++; if (got != 'h22) begin errors++; $display("FAIL b2b_din1 got=%0h exp=22", got); end
    checks++; if (done_cnt != 2) begin errors++; $display("FAIL b2b_done_count got=%0d exp=2", done_cnt); end
  endtask

  task automatic test_reset_mid_fill;
    int got;
    @(negedge clk);
    cmd_x = 9'd0; cmd_y = 8'd0; cmd_w = 9'd100; cmd_h = 8'd100; cmd_color = 8'h07;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (50) @(negedge clk);
    checks++; if (wen !== 1'b1) begin errors++; $display("FAIL midrst_fill_active got=%b exp=1", wen); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (wen !== 1'b0) begin errors++; $display("FAIL midrst_wen_async got=%b exp=0", wen); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy_async got=%b exp=0", busy); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready_after got=%b exp=1", cmd_ready); end
    run_cmd(9'd0, 8'd0, 9'd1, 8'd1, 8'h05);
    checks++; if (wr_addr.size() != 1) begin errors++; $display("FAIL midrst_1x1_count got=%0d exp=1", wr_addr.size()); end
    got = (wr_addr.size() > 0) ? wr_addr[0] : -1;
    checks++; if (got != 0) begin errors++; $display("FAIL midrst_1x1_addr got=%0d exp=0", got); end
    got = (wr_din.size() > 0) ? int'(wr_din[0]) : -1;
    checks++; if (got != 'h05) begin errors++; $display("FAIL midrst_1x1_din got=%0h exp=05", got); end
    @(negedge clk);
  endtask

`ifdef FB_WRITER_VSYNC_WAIT_EN
  task automatic test_vsync_wait;
    int early;
    int wa[$];
    int wn[$];
    int got;
    early = 0;
    @(negedge clk);
    cmd_x = 9'd0; cmd_y = 8'd0; cmd_w = 9'd2; cmd_h = 8'd1; cmd_color = 8'h15;
    cmd_valid = 1'b1;
    for (int n = 0; n <= 26; n++) begin
      if (n == 1) cmd_valid = 1'b0;
      if (n == 20) frame_sync = 1'b1;
      if (n == 21) frame_sync = 1'b0;
      if (wen) begin
        if (n < 21) early++;
        wa.push_back(int'(mem_addr));
        wn.push_back(n);
      end
      @(negedge clk);
    end
    checks++; if (early != 0) begin errors++; $display("FAIL vsync_early_writes got=%0d exp=0", early); end
    checks++; if (wa.size() != 2) begin errors++; $display("FAIL vsync_write_count got=%0d exp=2", wa.size()); end
    got = (wn.size() > 0) ? wn[0] : -1;
    checks++; if (got != 21) begin errors++; $display("FAIL vsync_first_write_cycle got=%0d exp=21", got); end
    got = (wa.size() > 0) ? wa[0] : -1;
    checks++; if (got != 0) begin errors++; $display("FAIL vsync_addr0 got=%0d exp=0", got); end
    got = (wa.size() > 1) ? wa[1] : -1;
    checks++; if (got != 1) begin errors++; $display("FAIL vsync_addr1 got=%0d exp=1", got); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic_fill();
    test_clipping();
    test_empty();
    test_back_to_back();
    test_reset_mid_fill();
`ifdef FB_WRITER_VSYNC_WAIT_EN
    test_vsync_wait();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog_timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
